// File: rtl/pc_trace_buffer.sv
// -----------------------------------------------------------------------------
// pc_trace_buffer
//
// Execution trace sink for the core's debug outputs (debug_pc / inst_debug).
// Once armed, it waits for a retired instruction whose PC matches trig_pc,
// then captures up to DEPTH retired (PC, instruction) pairs into a FIFO.
// The FIFO drains through a valid/ready read port in every state.
//
// State encoding on the `state` port:
//   0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//
// Optional feature (macro PC_TRACE_TIMESTAMP_EN):
//   Adds a free-running 32-bit cycle counter. Each entry also stores the
//   counter value seen at its write edge. The head timestamp is presented
//   on rd_time, which reads 0 while the FIFO is empty. With the macro
//   undefined, the counter, the extra storage and the rd_time port are absent.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   PC_W    PC field width
//   INST_W  instruction field width
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_valid  retired instruction present on in_pc/in_inst
//   in_pc     retired PC
//   in_inst   retired instruction
//   trig_pc   PC value that starts capture
//   arm       one-cycle pulse, IDLE -> ARMED
//   stop      one-cycle pulse, CAPTURE -> DONE
//   rd_valid  head entry valid
//   rd_ready  consumer accepts head entry
//   rd_pc     head entry PC (0 when empty)
//   rd_inst   head entry instruction (0 when empty)
//   count     occupied entries
//   state     current state
//   rd_time   head entry timestamp (only with PC_TRACE_TIMESTAMP_EN)
// -----------------------------------------------------------------------------
module pc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_inst,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     arm,
  input  logic                     stop,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [PC_W-1:0]          rd_pc,
  output logic [INST_W-1:0]        rd_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state
`ifdef PC_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              rd_time
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef PC_TRACE_TIMESTAMP_EN
  localparam int TS_W  = 32;
  localparam int ENT_W = TS_W + PC_W + INST_W;
`else
  localparam int ENT_W = PC_W + INST_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic [PTR_W-1:0]   wr_ptr_next_s;
  logic [PTR_W-1:0]   rd_ptr_next_s;
  logic [CNT_W-1:0]   count_next_s;

  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               wr_en_s;
  logic               clear_s;
  logic               trig_hit_s;

  logic [ENT_W-1:0]   mem_r [DEPTH];
  logic [ENT_W-1:0]   wr_entry_s;
  logic [ENT_W-1:0]   head_entry_s;

`ifdef PC_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]    ts_r;

  // Free-running cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_r <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end
`endif

  // Occupancy flags and handshake qualification.
  always_comb begin
    empty_s    = (count_r == {CNT_W{1'b0}});
    full_s     = (count_r == CNT_W'(DEPTH));
    pop_s      = (!empty_s) && rd_ready;
    trig_hit_s = in_valid && (in_pc == trig_pc);
    clear_s    = (state_r == ST_IDLE) && arm;
  end

  // Write enable: trigger entry in ARMED, then every in_valid while space
  // exists in CAPTURE. A same-cycle pop frees a slot even when full.
  always_comb begin
    wr_en_s = 1'b0;
    case (state_r)
      ST_ARMED:   wr_en_s = trig_hit_s;
      ST_CAPTURE: wr_en_s = in_valid && ((!full_s) || pop_s);
      ST_IDLE:    wr_en_s = 1'b0;
      ST_DONE:    wr_en_s = 1'b0;
      default:    wr_en_s = 1'b0;
    endcase
  end

  // Next pointer and count values. Arming discards all stale contents.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (clear_s) begin
      wr_ptr_next_s = {PTR_W{1'b0}};
      rd_ptr_next_s = {PTR_W{1'b0}};
      count_next_s  = {CNT_W{1'b0}};
    end else begin
      // Pointers wrap modulo DEPTH because DEPTH is a power of two.
      if (wr_en_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      count_next_s = count_r + CNT_W'(wr_en_s) - CNT_W'(pop_s);
    end
  end

  // Next-state decode. Exits are judged on the post-edge count so that
  // CAPTURE stops exactly at full and DONE leaves on the final pop.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_next_s = ST_ARMED;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (trig_hit_s) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (stop || (count_next_s == CNT_W'(DEPTH))) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (count_next_s == {CNT_W{1'b0}}) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control registers; an asynchronous reset drops any capture in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
    end
  end

  // Entry packing for the storage array.
  always_comb begin
`ifdef PC_TRACE_TIMESTAMP_EN
    wr_entry_s = {ts_r, in_pc, in_inst};
`else
    wr_entry_s = {in_pc, in_inst};
`endif
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_entry_s;
    end
  end

  // Head read is combinational and masked to zero while empty.
  always_comb begin
    if (empty_s) begin
      head_entry_s = {ENT_W{1'b0}};
    end else begin
      head_entry_s = mem_r[rd_ptr_r];
    end
  end

  // Output mapping.
  always_comb begin
    rd_valid = !empty_s;
    rd_inst  = head_entry_s[INST_W-1:0];
    rd_pc    = head_entry_s[INST_W +: PC_W];
    count    = count_r;
    state    = state_r;
`ifdef PC_TRACE_TIMESTAMP_EN
    rd_time  = head_entry_s[INST_W+PC_W +: TS_W];
`endif
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pc_trace_buffer
//
// Directed self-checking bench for pc_trace_buffer (DEPTH=16, PC_W=64,
// INST_W=32). Expected values are hand-computed from the PC sequence; the
// instruction paired with each PC is inst_of(pc). Timestamp checks are
// compiled only when PC_TRACE_TIMESTAMP_EN is defined.
// -----------------------------------------------------------------------------
module tb_pc_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   trig_pc;
  logic              arm;
  logic              stop;
  logic              rd_valid;
  logic              rd_ready;
  logic [PC_W-1:0]   rd_pc;
  logic [INST_W-1:0] rd_inst;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
`ifdef PC_TRACE_TIMESTAMP_EN
  logic [31:0]       rd_time;
  logic [31:0]       cyc;
  logic [31:0]       t0;
`endif

  int tests_run;
  int tests_failed;

  pc_trace_buffer #(
    .DEPTH  (DEPTH),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .trig_pc  (trig_pc),
    .arm      (arm),
    .stop     (stop),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_pc    (rd_pc),
    .rd_inst  (rd_inst),
    .count    (count),
    .state    (state)
`ifdef PC_TRACE_TIMESTAMP_EN
    ,
    .rd_time  (rd_time)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PC_TRACE_TIMESTAMP_EN
  // Reference cycle counter mirroring the timestamp's reset behaviour.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end
`endif

  function automatic logic [INST_W-1:0] inst_of(input logic [PC_W-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [PC_W-1:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst_of(pc);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_pc    = 64'd0;
    in_inst  = 32'd0;
    trig_pc  = 64'd0;
    arm      = 1'b0;
    stop     = 1'b0;
    rd_ready = 1'b0;

    // Reset state
    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_pc", rd_pc, 64'd0);
    check("rst_inst", 64'(rd_inst), 64'd0);
    reset = 1'b1;
    step();

    // Basic trigger and fill to full
    trig_pc = 64'h8;
    pulse_arm();
    check("arm_state", 64'(state), 64'd1);
    check("arm_count", 64'(count), 64'd0);
    feed(64'h0);
    check("pre_trig0", 64'(state), 64'd1);
    feed(64'h4);
    check("pre_trig4", 64'(state), 64'd1);
    check("pre_trig_cnt", 64'(count), 64'd0);
    feed(64'h8);
    check("trig_state", 64'(state), 64'd2);
    check("trig_count", 64'(count), 64'd1);
    check("trig_valid", 64'(rd_valid), 64'd1);
    check("trig_pc", rd_pc, 64'h8);
    check("trig_inst", 64'(rd_inst), 64'(inst_of(64'h8)));
    for (int k = 1; k < 16; k++) begin
      feed(64'h8 + 64'(4 * k));
      check("fill_count", 64'(count), 64'(k + 1));
      check("fill_state", 64'(state), (k == 15) ? 64'd3 : 64'd2);
    end
    feed(64'h48);
    check("full_drop_cnt", 64'(count), 64'd16);
    check("full_drop_st", 64'(state), 64'd3);
    check("full_head", rd_pc, 64'h8);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_pc", rd_pc, 64'h8 + 64'(4 * i));
      check("drain_inst", 64'(rd_inst), 64'(inst_of(64'h8 + 64'(4 * i))));
      step();
    end
    check("drained_state", 64'(state), 64'd0);
    check("drained_valid", 64'(rd_valid), 64'd0);
    check("drained_pc", rd_pc, 64'd0);
    step();
    check("empty_pop_cnt", 64'(count), 64'd0);
    rd_ready = 1'b0;

    // Stop early
    trig_pc = 64'h100;
    pulse_arm();
    for (int k = 0; k < 5; k++) feed(64'h100 + 64'(4 * k));
    check("pre_stop_cnt", 64'(count), 64'd5);
    check("pre_stop_st", 64'(state), 64'd2);
    stop = 1'b1;
    feed(64'h114);
    stop = 1'b0;
    check("stop_cnt", 64'(count), 64'd6);
    check("stop_state", 64'(state), 64'd3);
    feed(64'h118);
    check("done_nowrite", 64'(count), 64'd6);
    pulse_arm();
    check("done_arm_st", 64'(state), 64'd3);
    check("done_arm_cnt", 64'(count), 64'd6);
    rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("stop_drain_pc", rd_pc, 64'h100 + 64'(4 * i));
      step();
    end
    rd_ready = 1'b0;
    check("stop_idle", 64'(state), 64'd0);

    // Concurrent drain with pointer wrap
    trig_pc = 64'h200;
    pulse_arm();
    rd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      feed(64'h200 + 64'(4 * k));
      check("cc_count", 64'(count), 64'd1);
      check("cc_pc", rd_pc, 64'h200 + 64'(4 * k));
      check("cc_state", 64'(state), 64'd2);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cc_stop_st", 64'(state), 64'd3);
    check("cc_stop_cnt", 64'(count), 64'd0);
    check("cc_stop_vld", 64'(rd_valid), 64'd0);
    step();
    check("cc_idle", 64'(state), 64'd0);
    rd_ready = 1'b0;

    // Async reset mid-capture
    trig_pc = 64'h300;
    pulse_arm();
    for (int k = 0; k < 7; k++) feed(64'h300 + 64'(4 * k));
    check("ar_pre_cnt", 64'(count), 64'd7);
    check("ar_pre_st", 64'(state), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check("ar_state", 64'(state), 64'd0);
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(rd_valid), 64'd0);
    check("ar_pc", rd_pc, 64'd0);
    #10;
    reset = 1'b1;
    step();
    check("ar_post_st", 64'(state), 64'd0);

`ifdef PC_TRACE_TIMESTAMP_EN
    // Timestamps of consecutive entries
    trig_pc = 64'h400;
    pulse_arm();
    feed(64'h400);
    t0 = cyc - 32'd1;
    check("ts_head", 64'(rd_time), 64'(t0));
    feed(64'h404);
    feed(64'h408);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ts_cnt", 64'(count), 64'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ts_time", 64'(rd_time), 64'(t0 + 32'(i)));
      check("ts_pc", rd_pc, 64'h400 + 64'(4 * i));
      step();
    end
    rd_ready = 1'b0;
    check("ts_empty", 64'(rd_time), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_trace_buffer.md
Name: pc_trace_buffer

Overview:
Trace sink attached to the datapath debug outputs (debug_pc, inst_debug). It watches for a trigger PC, captures up to DEPTH retired (PC, instruction) pairs into an internal FIFO, and drains them through a valid/ready read port. It is used by benches and on-board debug logic to pull an execution trace out of the core.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two and at least 2
PC_W, 64, width of the PC field
INST_W, 32, width of the instruction field

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  a retired instruction is present on in_pc/in_inst this cycle
in_pc  in  PC_W  retired PC; connects to debug_pc
in_inst  in  INST_W  retired instruction; connects to inst_debug
trig_pc  in  PC_W  PC value that starts capture
arm  in  1  one-cycle pulse; IDLE -> ARMED
stop  in  1  one-cycle pulse; forces CAPTURE -> DONE
rd_valid  out  1  the FIFO head entry is valid
rd_ready  in  1  consumer accepts the head entry
rd_pc  out  PC_W  PC of the head entry
rd_inst  out  INST_W  instruction of the head entry
count  out  $clog2(DEPTH)+1  number of occupied entries
state  out  2  current state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wr_ptr, rd_ptr and count cleared to 0; rd_valid=0. rd_pc and rd_inst read 0 while empty. FIFO contents are not reset.
- Reset asserted mid-capture aborts immediately; all captured data is lost.
- rd_valid = (count != 0). rd_pc and rd_inst are driven combinationally from mem[rd_ptr] and read 0 when empty.
- Pop: occurs when rd_valid && rd_ready; rd_ptr increments and wraps modulo DEPTH. rd_ready while empty has no effect.
- Write: stores {in_pc, in_inst} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- A push and a pop in the same cycle leave count unchanged. Pops are allowed in every state.
- IDLE:
  - arm=1: go to ARMED; clear wr_ptr, rd_ptr and count. Any stale data is discarded.
  - Otherwise no writes.
- ARMED:
  - in_valid && in_pc==trig_pc: write the triggering entry; go to CAPTURE in the same edge.
  - Otherwise no writes. arm and stop are ignored.
- CAPTURE:
  - Each in_valid cycle writes one entry if the FIFO is not full, or if a simultaneous pop frees a slot.
  - Go to DONE when the post-edge count equals DEPTH.
  - Go to DONE on stop=1. If in_valid is high in the same cycle, that entry is still written if space allows.
  - arm is ignored.
- DONE:
  - No writes. The consumer drains the FIFO.
  - Go to IDLE on the edge where count becomes 0 (the last pop).
  - If count is already 0 on entry (for example, drained concurrently during CAPTURE), go to IDLE on the next cycle.
  - arm in DONE is ignored.
- Latency: an entry written at edge N is visible on rd_* after edge N (zero-cycle read-after-write once count updates).
- Full boundary: with count==DEPTH and no pop, in_valid data is dropped. This only occurs transiently, since CAPTURE exits to DONE at full.

Optional Feature:
Macro: PC_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, that wraps at 2^32.
  - Each entry also stores the counter value at its write edge.
  - Adds output port rd_time (out, 32), the timestamp of the head entry; it reads 0 when empty.
- Undefined: no counter, no rd_time port, no extra storage.

Test Plan:
- Basic trigger: reset; arm; drive in_valid=1 with PCs 0x0,0x4,... and trig_pc=0x8 -> state ARMED until PC 0x8, then CAPTURE. Head shows rd_pc=0x8 with its matching rd_inst; count increments by 1 per cycle.
- Fill to full: DEPTH=16, rd_ready=0 -> after 16 writes (PC 0x8..0x44), state=DONE and count=16. Draining 16 pops yields PCs 0x8..0x44 in order, then state=IDLE and rd_valid=0.
- Stop early: stop pulsed after 5 captured entries with in_valid=1 -> 6 entries stored, state=DONE, count=6.
- Concurrent drain: rd_ready=1 throughout CAPTURE -> count holds at 1, no drops, pointer wrap past index 15 is correct, and 40 PCs are read in order. After stop, the FIFO empties and state returns to IDLE.
- Async reset mid-CAPTURE with count=7: drive reset=0 between clock edges -> state=IDLE, count=0, rd_valid=0 immediately, without waiting for a clock edge.
- With PC_TRACE_TIMESTAMP_EN: trigger at cycle T -> consecutive entries read rd_time = T, T+1, T+2.
